// File: rtl/top_level_p3.sv
// rtl/top_level_p3.sv - program-3 engine: counts 5-bit pattern hits in a 32-byte message
// Results go to data memory bytes 33..35, then done is raised.

module top_level_p3_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] core [256];

  // Contents are deliberately left out of reset so preloaded data survives.
  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end

  assign rdata = core[addr];

endmodule

module top_level_p3 #(
  parameter int MSG_BYTES = 32,
  parameter int PAT_ADDR  = 32,
  parameter int OUT_ADDR  = 33
) (
  input  logic clk,
  input  logic reset,
  output logic done
);

  typedef enum logic [2:0] {
    RESET_ST,
    LOAD,
    SCAN,
    WR33,
    WR34,
    WR35,
    DONE_ST
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] idx;
  logic [7:0] pat;
  logic [7:0] prev;
  logic [7:0] ctb, cto, cts;

  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] inb_cnt;
  logic [7:0] cross_cnt;
  logic [7:0] cross_field;

  top_level_p3_mem dm1 (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // Windows f[k+4:k] for k = 0..3; the pattern is 8 bits, so a set upper bit never matches.
  function automatic logic [7:0] count_windows(input logic [7:0] f, input logic [7:0] p);
    logic [7:0] n;
    n = 8'd0;
    for (int k = 0; k < 4; k++) begin
      if ({3'b000, f[k +: 5]} == p) n = n + 8'd1;
    end
    return n;
  endfunction

  assign cross_field = {prev[3:0], mem_rdata[7:4]};
  assign inb_cnt     = count_windows(mem_rdata, pat);
  assign cross_cnt   = (idx == 8'd0) ? 8'd0 : count_windows(cross_field, pat);

  always_ff @(posedge clk) begin
    if (reset) state <= RESET_ST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_addr  = idx;
    mem_wdata = 8'd0;
    unique case (state)
      RESET_ST: state_nxt = LOAD;
      LOAD: begin
        mem_addr  = 8'(PAT_ADDR);
        state_nxt = SCAN;
      end
      SCAN: begin
        mem_addr = idx;
        if (idx == 8'(MSG_BYTES - 1)) state_nxt = WR33;
      end
      WR33: begin
        mem_we    = 1'b1;
        mem_addr  = 8'(OUT_ADDR);
        mem_wdata = ctb;
        state_nxt = WR34;
      end
      WR34: begin
        mem_we    = 1'b1;
        mem_addr  = 8'(OUT_ADDR + 1);
        mem_wdata = cto;
        state_nxt = WR35;
      end
      WR35: begin
        mem_we    = 1'b1;
        mem_addr  = 8'(OUT_ADDR + 2);
        mem_wdata = cts;
        state_nxt = DONE_ST;
      end
      DONE_ST: state_nxt = DONE_ST;
      default: state_nxt = RESET_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state == RESET_ST) begin
      idx  <= 8'd0;
      pat  <= 8'd0;
      prev <= 8'd0;
      ctb  <= 8'd0;
      cto  <= 8'd0;
      cts  <= 8'd0;
    end else begin
      case (state)
        LOAD: begin
          pat <= mem_rdata;
          idx <= 8'd0;
        end
        SCAN: begin
          ctb  <= ctb + inb_cnt;
          if (inb_cnt != 8'd0) cto <= cto + 8'd1;
          cts  <= cts + inb_cnt + cross_cnt;
          prev <= mem_rdata;
          idx  <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign done = (state == DONE_ST);

endmodule

// File: tb/tb_top_level_p3.sv
// tb/tb_top_level_p3.sv - scoreboard bench for top_level_p3
module tb_top_level_p3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    int         addr;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];

  top_level_p3 dut (
    .clk  (clk),
    .reset(reset),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: on each rising edge of done, pop the three result expectations.
  initial begin
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        for (int n = 0; n < 3; n++) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check(e.name, int'(dut.dm1.core[e.addr]), int'(e.val));
          end
        end
      end
      done_q = done;
    end
  end

  task automatic wait_done(input string name);
    int lat;
    lat = 0;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    check({name, "_latency"}, lat, 37);
    if (lat == 0) begin
      while (exp_q.size() > 0) void'(exp_q.pop_back());
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_case(input string name, input logic [7:0] fill, input logic [7:0] pat,
                          input logic [7:0] e33, input logic [7:0] e34, input logic [7:0] e35,
                          input int abort_after);
    exp_t e;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check({name, "_done_in_reset"}, int'(done), 0);
    for (int i = 0; i < 32; i++) dut.dm1.core[i] = fill;
    dut.dm1.core[32] = pat;
    e.name = {name, "_ctb"}; e.addr = 33; e.val = e33; exp_q.push_back(e);
    e.name = {name, "_cto"}; e.addr = 34; e.val = e34; exp_q.push_back(e);
    e.name = {name, "_cts"}; e.addr = 35; e.val = e35; exp_q.push_back(e);
    reset = 1'b0;
    if (abort_after > 0) begin
      repeat (abort_after) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check({name, "_done_at_abort"}, int'(done), 0);
      reset = 1'b0;
    end
    wait_done(name);
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_done", int'(done), 0);

    run_case("c1",   8'hC1, 8'h07, 8'd0,   8'd0,  8'd31,  0);
    run_case("zero", 8'h00, 8'h00, 8'd128, 8'd32, 8'd252, 0);
    run_case("alt",  8'h55, 8'h15, 8'd64,  8'd32, 8'd126, 0);
    run_case("high", 8'hFF, 8'hE7, 8'd0,   8'd0,  8'd0,   0);
    run_case("abrt", 8'hFF, 8'h1F, 8'd128, 8'd32, 8'd252, 12);

    bad = 0;
    for (int i = 0; i < 32; i++) if (dut.dm1.core[i] != 8'hFF) bad++;
    if (dut.dm1.core[32] != 8'h1F) bad++;
    check("msg_untouched", bad, 0);

    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!done) bad++;
      if (dut.dm1.core[33] != 8'd128 || dut.dm1.core[34] != 8'd32 || dut.dm1.core[35] != 8'd252) bad++;
    end
    check("hold_stable", bad, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
